// File: rtl/gpio_irq_apb.sv
// gpio_irq_apb
// APB GPIO controller with input synchronisation, a per-port debounce filter,
// atomic set/clear/toggle of the output register and per-pin edge/level
// interrupts. The interrupt flags are write-1-to-clear and drive one combined
// IRQ line.
//
// Ports:
//   pclk, presetn       clock and asynchronous active-low reset
//   paddr               byte address; bits [1:0] are ignored
//   psel/penable/pwrite APB control; pwdata write data; prdata read data
//   pready              always 1, so every access has zero wait states
//   pslverr             1 for an access to an unmapped offset
//   irq                 |(IFLAG & IE)
//   gpi                 asynchronous pin inputs
//   gpo / gpd           output values / direction (1 = output)
module gpio_irq_apb #(
    parameter int gpio_w      = 8,
    parameter int sync_stages = 2,
    parameter int deb_w       = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [5:0]        paddr,
    output logic [31:0]       prdata,
    input  logic [31:0]       pwdata,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    output logic              pready,
    output logic              pslverr,
    output logic              irq,
    input  logic [gpio_w-1:0] gpi,
    output logic [gpio_w-1:0] gpo,
    output logic [gpio_w-1:0] gpd
);

    // Word index of each register (byte offset / 4).
    localparam logic [3:0] OFF_GPO   = 4'd0;
    localparam logic [3:0] OFF_GPD   = 4'd1;
    localparam logic [3:0] OFF_GPI   = 4'd2;
    localparam logic [3:0] OFF_SET   = 4'd3;
    localparam logic [3:0] OFF_CLR   = 4'd4;
    localparam logic [3:0] OFF_TGL   = 4'd5;
    localparam logic [3:0] OFF_IE    = 4'd6;
    localparam logic [3:0] OFF_IMODE = 4'd7;
    localparam logic [3:0] OFF_IPOL  = 4'd8;
    localparam logic [3:0] OFF_IBOTH = 4'd9;
    localparam logic [3:0] OFF_IFLAG = 4'd10;
    localparam logic [3:0] OFF_DEB   = 4'd11;

    localparam logic [deb_w-1:0] DEB_ONE = deb_w'(1);

    logic [3:0]        reg_idx;
    logic              mapped;
    logic              wr_fire;
    logic              deb_wr;
    logic [gpio_w-1:0] wd;
    logic [gpio_w-1:0] w1c;

    logic [gpio_w-1:0] gpo_q,   gpo_d;
    logic [gpio_w-1:0] gpd_q,   gpd_d;
    logic [gpio_w-1:0] ie_q,    ie_d;
    logic [gpio_w-1:0] imode_q, imode_d;
    logic [gpio_w-1:0] ipol_q,  ipol_d;
    logic [gpio_w-1:0] iboth_q, iboth_d;
    logic [deb_w-1:0]  deb_q,   deb_d;

    logic [gpio_w-1:0] sync_q [sync_stages];
    logic [gpio_w-1:0] sync_w;
    logic [gpio_w-1:0] filt_q, filt_d;
    logic [gpio_w-1:0] filt_dly_q;
    logic [gpio_w-1:0] eflag_q, eflag_d;
    logic [gpio_w-1:0] iflag;
    logic [gpio_w-1:0] rd_field;
    logic [31:0]       rd_word;
    logic              unused_bits;

    assign reg_idx = paddr[5:2];
    assign mapped  = (reg_idx <= OFF_DEB);
    assign wr_fire = psel & penable & pwrite;
    assign deb_wr  = wr_fire && (reg_idx == OFF_DEB);
    assign wd      = pwdata[gpio_w-1:0];
    assign w1c     = (wr_fire && (reg_idx == OFF_IFLAG)) ? wd : '0;

    // Bits of the bus that no register uses.
    assign unused_bits = ^{pwdata, paddr[1:0]};

    // ---------------- register writes ----------------
    always_comb begin
        gpo_d   = gpo_q;
        gpd_d   = gpd_q;
        ie_d    = ie_q;
        imode_d = imode_q;
        ipol_d  = ipol_q;
        iboth_d = iboth_q;
        deb_d   = deb_q;
        if (wr_fire) begin
            case (reg_idx)
                OFF_GPO:   gpo_d   = wd;
                OFF_GPD:   gpd_d   = wd;
                OFF_SET:   gpo_d   = gpo_q | wd;
                OFF_CLR:   gpo_d   = gpo_q & ~wd;
                OFF_TGL:   gpo_d   = gpo_q ^ wd;
                OFF_IE:    ie_d    = wd;
                OFF_IMODE: imode_d = wd;
                OFF_IPOL:  ipol_d  = wd;
                OFF_IBOTH: iboth_d = wd;
                OFF_DEB:   deb_d   = pwdata[deb_w-1:0];
                default:   ;  // GPI, IFLAG (handled below) and unmapped
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            gpo_q      <= '0;
            gpd_q      <= '0;
            ie_q       <= '0;
            imode_q    <= '0;
            ipol_q     <= '0;
            iboth_q    <= '0;
            deb_q      <= '0;
            filt_q     <= '0;
            filt_dly_q <= '0;
            eflag_q    <= '0;
        end else begin
            gpo_q      <= gpo_d;
            gpd_q      <= gpd_d;
            ie_q       <= ie_d;
            imode_q    <= imode_d;
            ipol_q     <= ipol_d;
            iboth_q    <= iboth_d;
            deb_q      <= deb_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            eflag_q    <= eflag_d;
        end
    end

    // ---------------- input synchroniser ----------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < sync_stages; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpi;
            for (int i = 1; i < sync_stages; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_w = sync_q[sync_stages-1];

    // ---------------- per-pin debounce and edge flags ----------------
    generate
        for (genvar gi = 0; gi < gpio_w; gi++) begin : g_pin
            logic [deb_w-1:0] cnt_q, cnt_d;
            logic             filt_nxt;
            logic             rise, fall, edge_ev;

            // The filtered value only follows sync once the mismatch has
            // been seen for deb_q consecutive cycles (cnt reaches T-1 with
            // the mismatch still present).
            always_comb begin
                cnt_d    = '0;
                filt_nxt = filt_q[gi];
                if (deb_q == '0) begin
                    filt_nxt = sync_w[gi];
                end else if (sync_w[gi] != filt_q[gi]) begin
                    if (cnt_q == deb_q - DEB_ONE) begin
                        filt_nxt = sync_w[gi];
                    end else begin
                        cnt_d = cnt_q + DEB_ONE;
                    end
                end
                if (deb_wr) begin
                    cnt_d = '0;
                end
            end

            always_ff @(posedge pclk or negedge presetn) begin
                if (!presetn) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign filt_d[gi] = filt_nxt;

            assign rise    = filt_q[gi] & ~filt_dly_q[gi];
            assign fall    = ~filt_q[gi] & filt_dly_q[gi];
            assign edge_ev = iboth_q[gi] ? (rise | fall)
                                         : (ipol_q[gi] ? fall : rise);

            // Sticky edge flag; a set event in the same cycle as a W1C wins.
            // Pins in level mode leave the stored edge flag untouched so a
            // mode change neither sets nor clears it.
            assign eflag_d[gi] = imode_q[gi] ? eflag_q[gi]
                                             : ((eflag_q[gi] & ~w1c[gi]) | edge_ev);
        end
    endgenerate

    // Level-mode pins report the live filtered level, edge pins the sticky flag.
    assign iflag = (imode_q & (filt_q ^ ipol_q)) | (~imode_q & eflag_q);
    assign irq   = |(iflag & ie_q);

    // ---------------- read path ----------------
    always_comb begin
        rd_field = '0;
        case (reg_idx)
            OFF_GPO:   rd_field = gpo_q;
            OFF_GPD:   rd_field = gpd_q;
            OFF_GPI:   rd_field = filt_q;
            OFF_IE:    rd_field = ie_q;
            OFF_IMODE: rd_field = imode_q;
            OFF_IPOL:  rd_field = ipol_q;
            OFF_IBOTH: rd_field = iboth_q;
            OFF_IFLAG: rd_field = iflag;
            default:   rd_field = '0;  // write-only and unmapped read as 0
        endcase
        rd_word = '0;
        if (reg_idx == OFF_DEB) begin
            rd_word[deb_w-1:0] = deb_q;
        end else begin
            rd_word[gpio_w-1:0] = rd_field;
        end
    end

    // Bus outputs are forced quiet while reset is held.
    assign prdata  = (presetn && psel && !pwrite) ? rd_word : 32'd0;
    assign pslverr = presetn & psel & penable & ~mapped;
    assign pready  = 1'b1;

    assign gpo = gpo_q;
    assign gpd = gpd_q;

endmodule
